// File: rtl/altera_tse_multi_chan_reset_sequencer.sv
// Reset/power-down sequencer for an N-channel transceiver PMA sharing one TX PLL.
// Optional macro TSE_RSEQ_MANUAL_RESTART_EN adds manual_mode/rx_restart and a per-channel hold state.
module altera_tse_multi_chan_reset_sequencer #(
  parameter int NUM_CHANNELS       = 1,
  parameter int SYNCHRONIZER_DEPTH = 3,
  parameter int PWRDN_CYCLES       = 64,
  parameter int PLL_LOCK_CYCLES    = 16,
  parameter int LTD_CYCLES         = 200
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    powerdown_all,
  input  logic                    pll_locked,
  input  logic [NUM_CHANNELS-1:0] rx_is_lockedtodata,
  input  logic                    rx_oc_busy,
`ifdef TSE_RSEQ_MANUAL_RESTART_EN
  input  logic                    manual_mode,
  input  logic [NUM_CHANNELS-1:0] rx_restart,
`endif
  output logic                    gxb_powerdown,
  output logic                    pll_powerdown,
  output logic                    tx_digitalreset,
  output logic [NUM_CHANNELS-1:0] rx_analogreset,
  output logic [NUM_CHANNELS-1:0] rx_digitalreset,
  output logic                    tx_ready,
  output logic [NUM_CHANNELS-1:0] rx_ready
);

  localparam int MAX_AB     = (PWRDN_CYCLES > PLL_LOCK_CYCLES) ? PWRDN_CYCLES : PLL_LOCK_CYCLES;
  localparam int MAX_CYCLES = (MAX_AB > LTD_CYCLES) ? MAX_AB : LTD_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [CW-1:0] CNT_SAT    = {CW{1'b1}};
  localparam logic [CW-1:0] PWRDN_LAST = CW'(PWRDN_CYCLES - 1);
  localparam logic [CW-1:0] PLL_LAST   = CW'(PLL_LOCK_CYCLES - 1);
  localparam logic [CW-1:0] LTD_LAST   = CW'(LTD_CYCLES - 1);

  typedef enum logic [1:0] {
    G_PWRDN,
    G_PLL_WAIT,
    G_RUN
  } g_state_t;

  typedef enum logic [1:0] {
    C_ANALOG,
    C_LTD_WAIT,
`ifdef TSE_RSEQ_MANUAL_RESTART_EN
    C_HOLD,
`endif
    C_DONE
  } ch_state_t;

  logic [SYNCHRONIZER_DEPTH-1:0]                   pll_sync_q;
  logic [SYNCHRONIZER_DEPTH-1:0]                   busy_sync_q;
  logic [SYNCHRONIZER_DEPTH-1:0][NUM_CHANNELS-1:0] ltd_sync_q;

  logic                    pll_locked_s;
  logic                    rx_oc_busy_s;
  logic [NUM_CHANNELS-1:0] lockedtodata_s;

  g_state_t    g_state;
  logic [CW-1:0] g_cnt;
  ch_state_t   ch_state [NUM_CHANNELS];
  logic [CW-1:0] ch_cnt [NUM_CHANNELS];
  logic        ch_run;

  // Busy resets high so channels never leave analog reset before the first real sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pll_sync_q  <= '0;
      busy_sync_q <= '1;
      ltd_sync_q  <= '0;
    end else begin
      pll_sync_q  <= {pll_sync_q[SYNCHRONIZER_DEPTH-2:0], pll_locked};
      busy_sync_q <= {busy_sync_q[SYNCHRONIZER_DEPTH-2:0], rx_oc_busy};
      ltd_sync_q  <= {ltd_sync_q[SYNCHRONIZER_DEPTH-2:0], rx_is_lockedtodata};
    end
  end

  assign pll_locked_s   = pll_sync_q[SYNCHRONIZER_DEPTH-1];
  assign rx_oc_busy_s   = busy_sync_q[SYNCHRONIZER_DEPTH-1];
  assign lockedtodata_s = ltd_sync_q[SYNCHRONIZER_DEPTH-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      g_state         <= G_PWRDN;
      g_cnt           <= '0;
      gxb_powerdown   <= 1'b1;
      pll_powerdown   <= 1'b1;
      tx_digitalreset <= 1'b1;
      tx_ready        <= 1'b0;
    end else if (powerdown_all) begin
      g_state         <= G_PWRDN;
      g_cnt           <= '0;
      gxb_powerdown   <= 1'b1;
      pll_powerdown   <= 1'b1;
      tx_digitalreset <= 1'b1;
      tx_ready        <= 1'b0;
    end else begin
      case (g_state)
        G_PWRDN: begin
          if (g_cnt == PWRDN_LAST) begin
            g_state       <= G_PLL_WAIT;
            g_cnt         <= '0;
            gxb_powerdown <= 1'b0;
            pll_powerdown <= 1'b0;
          end else if (g_cnt != CNT_SAT) begin
            g_cnt <= g_cnt + CW'(1);
          end
        end
        G_PLL_WAIT: begin
          if (!pll_locked_s) begin
            g_cnt <= '0;
          end else if (g_cnt == PLL_LAST) begin
            g_state         <= G_RUN;
            g_cnt           <= '0;
            tx_digitalreset <= 1'b0;
            tx_ready        <= 1'b1;
          end else if (g_cnt != CNT_SAT) begin
            g_cnt <= g_cnt + CW'(1);
          end
        end
        G_RUN: begin
          if (!pll_locked_s) begin
            g_state         <= G_PLL_WAIT;
            g_cnt           <= '0;
            tx_digitalreset <= 1'b1;
            tx_ready        <= 1'b0;
          end
        end
        default: begin
          g_state         <= G_PWRDN;
          g_cnt           <= '0;
          gxb_powerdown   <= 1'b1;
          pll_powerdown   <= 1'b1;
          tx_digitalreset <= 1'b1;
          tx_ready        <= 1'b0;
        end
      endcase
    end
  end

  // Channels advance only while the TX side is running and stays running on this edge.
  assign ch_run = (g_state == G_RUN) && pll_locked_s && !powerdown_all;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        ch_state[i] <= C_ANALOG;
        ch_cnt[i]   <= '0;
      end
      rx_analogreset  <= '1;
      rx_digitalreset <= '1;
      rx_ready        <= '0;
    end else if (!ch_run) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        ch_state[i] <= C_ANALOG;
        ch_cnt[i]   <= '0;
      end
      rx_analogreset  <= '1;
      rx_digitalreset <= '1;
      rx_ready        <= '0;
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        case (ch_state[i])
          C_ANALOG: begin
            if (!rx_oc_busy_s) begin
              ch_state[i]       <= C_LTD_WAIT;
              ch_cnt[i]         <= '0;
              rx_analogreset[i] <= 1'b0;
            end
          end
          C_LTD_WAIT: begin
            if (rx_oc_busy_s) begin
              ch_state[i]       <= C_ANALOG;
              ch_cnt[i]         <= '0;
              rx_analogreset[i] <= 1'b1;
            end else if (!lockedtodata_s[i]) begin
              ch_cnt[i] <= '0;
            end else if (ch_cnt[i] == LTD_LAST) begin
              ch_state[i]        <= C_DONE;
              ch_cnt[i]          <= '0;
              rx_digitalreset[i] <= 1'b0;
              rx_ready[i]        <= 1'b1;
            end else if (ch_cnt[i] != CNT_SAT) begin
              ch_cnt[i] <= ch_cnt[i] + CW'(1);
            end
          end
          C_DONE: begin
            if (!lockedtodata_s[i]) begin
`ifdef TSE_RSEQ_MANUAL_RESTART_EN
              if (manual_mode) begin
                ch_state[i]        <= C_HOLD;
                ch_cnt[i]          <= '0;
                rx_digitalreset[i] <= 1'b1;
                rx_ready[i]        <= 1'b0;
              end else begin
                ch_state[i]        <= C_ANALOG;
                ch_cnt[i]          <= '0;
                rx_analogreset[i]  <= 1'b1;
                rx_digitalreset[i] <= 1'b1;
                rx_ready[i]        <= 1'b0;
              end
`else
              ch_state[i]        <= C_ANALOG;
              ch_cnt[i]          <= '0;
              rx_analogreset[i]  <= 1'b1;
              rx_digitalreset[i] <= 1'b1;
              rx_ready[i]        <= 1'b0;
`endif
            end
          end
`ifdef TSE_RSEQ_MANUAL_RESTART_EN
          C_HOLD: begin
            if (rx_restart[i]) begin
              ch_state[i]       <= C_ANALOG;
              ch_cnt[i]         <= '0;
              rx_analogreset[i] <= 1'b1;
            end
          end
`endif
          default: begin
            ch_state[i]        <= C_ANALOG;
            ch_cnt[i]          <= '0;
            rx_analogreset[i]  <= 1'b1;
            rx_digitalreset[i] <= 1'b1;
            rx_ready[i]        <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_altera_tse_multi_chan_reset_sequencer.sv
// Self-checking bench: directed scenarios plus random traffic against a cycle-level reference model.
module tb_altera_tse_multi_chan_reset_sequencer;

  localparam int NCH = 2;
  localparam int SD  = 2;
  localparam int PWR = 4;
  localparam int PLL = 3;
  localparam int LTD = 5;

  localparam int PH_PWRDN = 0, PH_PLLWAIT = 1, PH_RUN = 2;
  localparam int CH_ANALOG = 0, CH_LTDWAIT = 1, CH_DONE = 2, CH_HOLD = 3;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           powerdown_all = 1'b0;
  logic           pll_locked = 1'b0;
  logic [NCH-1:0] rx_is_lockedtodata = '0;
  logic           rx_oc_busy = 1'b1;
`ifdef TSE_RSEQ_MANUAL_RESTART_EN
  logic           manual_mode = 1'b0;
  logic [NCH-1:0] rx_restart = '0;
`endif
  logic           gxb_powerdown, pll_powerdown, tx_digitalreset, tx_ready;
  logic [NCH-1:0] rx_analogreset, rx_digitalreset, rx_ready;

  int testsRun = 0;
  int testsFailed = 0;
  int edgeCount = 0;

  // Reference model state: phase of TX side, run lengths, per-channel phase, synchronizer delay lines.
  int gPhase, gCycles, gStreak;
  int chPhase [NCH];
  int chStreak [NCH];
  bit pllHist [$];
  bit busyHist [$];
  logic [NCH-1:0] ltdHist [$];

  altera_tse_multi_chan_reset_sequencer #(
    .NUM_CHANNELS(NCH), .SYNCHRONIZER_DEPTH(SD), .PWRDN_CYCLES(PWR),
    .PLL_LOCK_CYCLES(PLL), .LTD_CYCLES(LTD)
  ) dut (
    .clk(clk), .reset_n(reset_n), .powerdown_all(powerdown_all),
    .pll_locked(pll_locked), .rx_is_lockedtodata(rx_is_lockedtodata), .rx_oc_busy(rx_oc_busy),
`ifdef TSE_RSEQ_MANUAL_RESTART_EN
    .manual_mode(manual_mode), .rx_restart(rx_restart),
`endif
    .gxb_powerdown(gxb_powerdown), .pll_powerdown(pll_powerdown), .tx_digitalreset(tx_digitalreset),
    .rx_analogreset(rx_analogreset), .rx_digitalreset(rx_digitalreset),
    .tx_ready(tx_ready), .rx_ready(rx_ready)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, actual, expected, edgeCount);
    end
  endtask

  task automatic modelReset();
    gPhase = PH_PWRDN; gCycles = 0; gStreak = 0;
    for (int i = 0; i < NCH; i++) begin chPhase[i] = CH_ANALOG; chStreak[i] = 0; end
    pllHist.delete(); busyHist.delete(); ltdHist.delete();
    for (int i = 0; i < SD; i++) begin
      pllHist.push_back(1'b0); busyHist.push_back(1'b1); ltdHist.push_back('0);
    end
  endtask

  task automatic modelStep();
    bit pllS, busyS, chActive;
    logic [NCH-1:0] ltdS;
    pllS = pllHist.pop_front();   pllHist.push_back(pll_locked);
    busyS = busyHist.pop_front(); busyHist.push_back(rx_oc_busy);
    ltdS = ltdHist.pop_front();   ltdHist.push_back(rx_is_lockedtodata);
    chActive = (gPhase == PH_RUN) && pllS && !powerdown_all;
    if (powerdown_all) begin
      gPhase = PH_PWRDN; gCycles = 0; gStreak = 0;
    end else if (gPhase == PH_PWRDN) begin
      gCycles++;
      if (gCycles == PWR) begin gPhase = PH_PLLWAIT; gStreak = 0; end
    end else if (gPhase == PH_PLLWAIT) begin
      gStreak = pllS ? gStreak + 1 : 0;
      if (gStreak == PLL) gPhase = PH_RUN;
    end else if (!pllS) begin
      gPhase = PH_PLLWAIT; gStreak = 0;
    end
    for (int i = 0; i < NCH; i++) begin
      if (!chActive) begin
        chPhase[i] = CH_ANALOG;
      end else if (chPhase[i] == CH_ANALOG) begin
        if (!busyS) begin chPhase[i] = CH_LTDWAIT; chStreak[i] = 0; end
      end else if (chPhase[i] == CH_LTDWAIT) begin
        if (busyS) chPhase[i] = CH_ANALOG;
        else begin
          chStreak[i] = ltdS[i] ? chStreak[i] + 1 : 0;
          if (chStreak[i] == LTD) chPhase[i] = CH_DONE;
        end
      end else if (chPhase[i] == CH_DONE) begin
`ifdef TSE_RSEQ_MANUAL_RESTART_EN
        if (!ltdS[i]) chPhase[i] = manual_mode ? CH_HOLD : CH_ANALOG;
`else
        if (!ltdS[i]) chPhase[i] = CH_ANALOG;
`endif
      end else begin
`ifdef TSE_RSEQ_MANUAL_RESTART_EN
        if (rx_restart[i]) chPhase[i] = CH_ANALOG;
`endif
      end
    end
  endtask

  task automatic checkAll();
    logic [NCH-1:0] expA, expD, expR;
    bit invOk;
    invOk = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      expA[i] = (chPhase[i] == CH_ANALOG);
      expD[i] = (chPhase[i] != CH_DONE);
      expR[i] = (chPhase[i] == CH_DONE);
      if (!rx_digitalreset[i] && (rx_analogreset[i] || tx_digitalreset)) invOk = 1'b0;
    end
    checkOutput("gxb_powerdown", 32'(gxb_powerdown), 32'(gPhase == PH_PWRDN));
    checkOutput("pll_powerdown", 32'(pll_powerdown), 32'(gPhase == PH_PWRDN));
    checkOutput("tx_digitalreset", 32'(tx_digitalreset), 32'(gPhase != PH_RUN));
    checkOutput("tx_ready", 32'(tx_ready), 32'(gPhase == PH_RUN));
    checkOutput("rx_analogreset", 32'(rx_analogreset), 32'(expA));
    checkOutput("rx_digitalreset", 32'(rx_digitalreset), 32'(expD));
    checkOutput("rx_ready", 32'(rx_ready), 32'(expR));
    checkOutput("order_invariant", 32'(invOk), 32'd1);
  endtask

  task automatic applyStimulus(input bit pd, input bit pll, input logic [NCH-1:0] ltd, input bit busy);
    powerdown_all = pd; pll_locked = pll; rx_is_lockedtodata = ltd; rx_oc_busy = busy;
    @(posedge clk);
    modelStep();
    @(negedge clk);
    edgeCount++;
    checkAll();
  endtask

  task automatic runUntilReady(input int limit, input string tag);
    for (int n = 0; n < limit && rx_ready != '1; n++) applyStimulus(1'b0, 1'b1, '1, 1'b0);
    checkOutput(tag, 32'(rx_ready), 32'({NCH{1'b1}}));
  endtask

  initial begin
    int pwrEdge, txEdge, anaEdge, rdyEdge, startEdge, ch0Down, ch1Down;
    bit pllRaw, busyR;
    logic [NCH-1:0] ltdR;

    modelReset();
    repeat (3) @(negedge clk);
    checkAll();

    // Power-up with the PLL reporting lock only once its power-down is released.
    reset_n = 1'b1;
    edgeCount = 0; pllRaw = 1'b0;
    pwrEdge = -1; txEdge = -1; anaEdge = -1; rdyEdge = -1;
    for (int n = 0; n < 40 && rdyEdge < 0; n++) begin
      applyStimulus(1'b0, pllRaw, 2'b11, 1'b0);
      if (!pllRaw && !pll_powerdown) begin pllRaw = 1'b1; pwrEdge = edgeCount; end
      if (txEdge < 0 && tx_ready) txEdge = edgeCount;
      if (anaEdge < 0 && rx_analogreset == '0) anaEdge = edgeCount;
      if (rdyEdge < 0 && rx_ready == '1) rdyEdge = edgeCount;
    end
    checkOutput("pwrdn_release_edge", 32'(pwrEdge), 32'd4);
    checkOutput("tx_ready_edge", 32'(txEdge), 32'd9);
    checkOutput("rx_analog_release_edge", 32'(anaEdge), 32'd10);
    checkOutput("rx_ready_edge", 32'(rdyEdge), 32'd15);

    // PLL glitch timed so the synced low lands where the lock count would complete.
    applyStimulus(1'b1, 1'b1, '1, 1'b0);
    startEdge = edgeCount; txEdge = -1;
    for (int n = 0; n < 30 && txEdge < 0; n++) begin
      applyStimulus(1'b0, (edgeCount + 1) != (startEdge + 5), '1, 1'b0);
      if (tx_ready) txEdge = edgeCount;
    end
    checkOutput("pll_glitch_tx_delay", 32'(txEdge - startEdge), 32'd10);
    runUntilReady(40, "ready_after_glitch");

    // Single-cycle lock loss on channel 1.
    ch0Down = 0; ch1Down = 0;
    for (int n = 0; n < 20; n++) begin
      applyStimulus(1'b0, 1'b1, (n == 0) ? 2'b01 : 2'b11, 1'b0);
      if (!rx_ready[0]) ch0Down++;
      if (!rx_ready[1]) ch1Down++;
    end
    checkOutput("ch0_undisturbed", 32'(ch0Down), 32'd0);
    checkOutput("ch1_down_cycles", 32'(ch1Down), 32'd6);

    // Busy held through a full restart keeps both channels in analog reset.
    applyStimulus(1'b1, 1'b1, '1, 1'b1);
    for (int n = 0; n < 30; n++) applyStimulus(1'b0, 1'b1, '1, 1'b1);
    checkOutput("busy_hold_analog", 32'(rx_analogreset), 32'(2'b11));
    checkOutput("busy_hold_tx_ready", 32'(tx_ready), 32'd1);
    startEdge = edgeCount + 1; anaEdge = -1;
    for (int n = 0; n < 10 && anaEdge < 0; n++) begin
      applyStimulus(1'b0, 1'b1, '1, 1'b0);
      if (rx_analogreset == '0) anaEdge = edgeCount;
    end
    checkOutput("busy_release_delay", 32'(anaEdge - startEdge), 32'd2);
    runUntilReady(20, "ready_after_busy");

    // powerdown_all while fully running, then the whole sequence again.
    applyStimulus(1'b1, 1'b1, '1, 1'b0);
    checkOutput("pdall_outputs",
      32'({gxb_powerdown, pll_powerdown, tx_digitalreset, rx_analogreset, rx_digitalreset, tx_ready, rx_ready}),
      32'({1'b1, 1'b1, 1'b1, 2'b11, 2'b11, 1'b0, 2'b00}));
    runUntilReady(40, "ready_after_pdall");

    // Asynchronous reset in the middle of the lock-to-data wait.
    applyStimulus(1'b1, 1'b1, '1, 1'b0);
    for (int n = 0; n < 30 && rx_analogreset != '0; n++) applyStimulus(1'b0, 1'b1, '1, 1'b0);
    applyStimulus(1'b0, 1'b1, '1, 1'b0);
    applyStimulus(1'b0, 1'b1, '1, 1'b0);
    #2 reset_n = 1'b0;
    #1 modelReset();
    checkAll();
    checkOutput("async_reset_outputs",
      32'({gxb_powerdown, pll_powerdown, tx_digitalreset, rx_analogreset, rx_digitalreset, tx_ready, rx_ready}),
      32'({1'b1, 1'b1, 1'b1, 2'b11, 2'b11, 1'b0, 2'b00}));
    @(posedge clk);
    #1 checkAll();
    @(negedge clk);
    reset_n = 1'b1;
    runUntilReady(40, "ready_after_reset");

`ifdef TSE_RSEQ_MANUAL_RESTART_EN
    // Manual recovery: channel 0 parks until restarted.
    manual_mode = 1'b1;
    applyStimulus(1'b0, 1'b1, 2'b10, 1'b0);
    for (int n = 0; n < 50; n++) applyStimulus(1'b0, 1'b1, '1, 1'b0);
    checkOutput("hold_rx_ready", 32'(rx_ready), 32'(2'b10));
    checkOutput("hold_rx_analog", 32'(rx_analogreset[0]), 32'd0);
    checkOutput("hold_rx_digital", 32'(rx_digitalreset[0]), 32'd1);
    rx_restart = 2'b01;
    applyStimulus(1'b0, 1'b1, '1, 1'b0);
    rx_restart = '0;
    startEdge = edgeCount; rdyEdge = -1;
    for (int n = 0; n < 20 && rdyEdge < 0; n++) begin
      applyStimulus(1'b0, 1'b1, '1, 1'b0);
      if (rx_ready[0]) rdyEdge = edgeCount;
    end
    checkOutput("restart_ready_delay", 32'(rdyEdge - startEdge), 32'd6);
    manual_mode = 1'b0;
`endif

    // Random traffic: rare lock drops, busy episodes and power-down pulses.
    busyR = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 79) == 0) busyR = !busyR;
      for (int i = 0; i < NCH; i++) ltdR[i] = ($urandom_range(0, 59) != 0);
`ifdef TSE_RSEQ_MANUAL_RESTART_EN
      if ($urandom_range(0, 199) == 0) manual_mode = !manual_mode;
      for (int i = 0; i < NCH; i++) rx_restart[i] = ($urandom_range(0, 29) == 0);
`endif
      applyStimulus($urandom_range(0, 399) == 0, $urandom_range(0, 99) != 0, ltdR, busyR);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
